customer_counter_ctrl: RTL and testbench

//  Sequencer/arbiter that shares one customer_counter between NUM_REQ requesters.

---
 rtl/cnt_ctrl_pkg.sv | 20 ++
 rtl/cnt_ctrl_rr_arb.sv | 35 +++
 rtl/customer_counter_ctrl.sv | 156 +++++++++++++++
 tb/tb_customer_counter_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/cnt_ctrl_pkg.sv
// Shared types and helpers for the customer_counter sequencer/arbiter.
// Holds the FSM state encoding and the requester-index width helper.
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int NUM_REQ_DEF = 4;
    localparam int IDX_W_DEF   = $clog2(NUM_REQ_DEF);

endpackage

// File: rtl/cnt_ctrl_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// Produces a one-hot grant and the encoded index of the winner.
module cnt_ctrl_rr_arb
    import cnt_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    int   cand_s;
    logic found_s;
    logic hit_s;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        cand_s  = 0;
        hit_s   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s        = (int'(ptr) + off) % NUM_REQ;
            hit_s         = !found_s && req[cand_s];
            grant[cand_s] = hit_s;
            idx           = hit_s ? IDX_W'(cand_s) : idx;
            found_s       = found_s | hit_s;
        end
    end

endmodule

// File: rtl/customer_counter_ctrl.sv
// Shares one customer_counter between NUM_REQ requesters: grant, clear, count to target, done.
// Optional stall watchdog is built when CNT_CTRL_WDOG_EN is defined.
module customer_counter_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0]         cnt_out,
    output logic                     cnt_clr,
    output logic                     cnt_en,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     err
);

    localparam int IDX_W = idx_width(NUM_REQ);

    state_t               state_r;
    state_t               state_s;
    logic [IDX_W-1:0]     ptr_r;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     arb_idx_s;
    logic [NUM_REQ-1:0]   arb_gnt_s;
    logic [NUM_REQ-1:0]   gnt_r;
    logic [WIDTH-1:0]     tgt_r;
    logic                 at_tgt_s;
    logic                 wdog_hit_s;
    logic                 err_pend_s;

    cnt_ctrl_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_r),
        .grant (arb_gnt_s),
        .idx   (arb_idx_s)
    );

    assign at_tgt_s = (cnt_out == tgt_r);
    assign gnt      = gnt_r;

`ifdef CNT_CTRL_WDOG_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_r;
    logic [WIDTH-1:0]   prev_r;
    logic               abort_r;

    assign wdog_hit_s = (stall_r == STALL_W'(TIMEOUT)) && !at_tgt_s;
    assign err_pend_s = abort_r;

    // Stall counter: restarts on any counter movement, advances while enabled but frozen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r <= '0;
            prev_r  <= '0;
            abort_r <= 1'b0;
        end else begin
            prev_r  <= cnt_out;
            abort_r <= (state_r == COUNT) && wdog_hit_s;
            if (state_r != COUNT) begin
                stall_r <= '0;
            end else if (cnt_out != prev_r) begin
                stall_r <= '0;
            end else if (cnt_en) begin
                stall_r <= stall_r + 1'b1;
            end else begin
                stall_r <= stall_r;
            end
        end
    end
`else
    assign wdog_hit_s = 1'b0;
    assign err_pend_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s = CLEAR;
                end else begin
                    state_s = IDLE;
                end
            end
            CLEAR: state_s = COUNT;
            COUNT: begin
                if (at_tgt_s || wdog_hit_s) begin
                    state_s = DONE;
                end else begin
                    state_s = COUNT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Run bookkeeping: owner and target latched at grant, pointer advanced on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
            idx_r <= '0;
            gnt_r <= '0;
            tgt_r <= '0;
        end else if ((state_r == IDLE) && (|req)) begin
            idx_r <= arb_idx_s;
            gnt_r <= arb_gnt_s;
            tgt_r <= tgt[int'(arb_idx_s)*WIDTH +: WIDTH];
        end else if (state_r == DONE) begin
            gnt_r <= '0;
            ptr_r <= (idx_r == IDX_W'(NUM_REQ - 1)) ? '0 : idx_r + 1'b1;
        end else begin
            gnt_r <= gnt_r;
        end
    end

    // Output decode; cnt_en follows cnt_out directly so the counter halts on the target.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        done    = '0;
        busy    = 1'b1;
        err     = 1'b0;
        case (state_r)
            IDLE:  busy    = 1'b0;
            CLEAR: cnt_clr = 1'b1;
            COUNT: cnt_en  = !at_tgt_s;
            DONE: begin
                done = gnt_r;
                err  = err_pend_s;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_customer_counter_ctrl.sv
// Directed bench for customer_counter_ctrl with a behavioural customer_counter in the loop.
// Cycle numbers below count from the edge that samples a new request (that cycle is 1).
module tb_customer_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [15:0] tgt = 16'h0000;
    logic [3:0]  cnt = 4'd0;
    logic        freeze = 1'b0;
    logic        cnt_clr;
    logic        cnt_en;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    customer_counter_ctrl #(.WIDTH(4), .NUM_REQ(4), .TIMEOUT(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .tgt     (tgt),
        .cnt_out (cnt),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Behavioural customer_counter: clear wins, then increment when enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= 4'd0;
        else if (cnt_clr) cnt <= 4'd0;
        else if (cnt_en && !freeze) cnt <= cnt + 4'd1;
        else cnt <= cnt;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // Wait for IDLE with a bounded budget, counting done pulses on the way.
    task automatic wait_idle(input string tag, input logic [3:0] exp_done, input int exp_pulses);
        int pulses = 0;
        int left = 40;
        while (busy && left > 0) begin
            if (done != 4'b0000) begin
                pulses++;
                check({tag, "_done_who"}, done, exp_done);
            end
            tick();
            left--;
        end
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_pulses"}, pulses, exp_pulses);
    endtask

    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int err_seen;

    initial begin
        // Reset state
        #1;
        check("rst_gnt",  gnt,  4'b0000);
        check("rst_done", done, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_clr",  cnt_clr, 1'b0);
        check("rst_en",   cnt_en,  1'b0);
        check("rst_err",  err,  1'b0);
        do_reset();

        // 1: single req[1], tgt[1]=3
        req = 4'b0010;
        tgt = 16'h0030;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            check("t1_gnt",  gnt,     (c >= 1 && c <= 6) ? 4'b0010 : 4'b0000);
            check("t1_clr",  cnt_clr, (c == 1) ? 1'b1 : 1'b0);
            check("t1_en",   cnt_en,  (c >= 2 && c <= 4) ? 1'b1 : 1'b0);
            check("t1_done", done,    (c == 6) ? 4'b0010 : 4'b0000);
        end
        check("t1_out",  cnt,  4'd3);
        check("t1_busy", busy, 1'b0);

        // 2: all requesting, all targets 1, pointer restarted at 0
        do_reset();
        req = 4'b1111;
        tgt = 16'h1111;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (c % 5 == 1) check("t2_gnt", gnt, exp_order[(c - 1) / 5]);
            if (c % 5 == 4) check("t2_done", done, exp_order[(c - 1) / 5]);
            if (c % 5 == 0) check("t2_gap", busy, 1'b0);
        end
        req = 4'b0000;
        wait_idle("t2", 4'b0001, 1);

        // 3: target 0 after counter left at 1
        req = 4'b0001;
        tgt = 16'h0000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            check("t3_en",   cnt_en, 1'b0);
            check("t3_done", done, (c == 3) ? 4'b0001 : 4'b0000);
        end
        check("t3_out", cnt, 4'd0);

        // 4: full-scale target, target changed mid-run
        req = 4'b0100;
        tgt = 16'h0F00;
        for (int c = 1; c <= 19; c++) begin
            tick();
            if (c == 1) begin
                req = 4'b0000;
                tgt = 16'h0500;
            end
            if (c == 17) check("t4_out15", cnt, 4'd15);
            if (c == 17) check("t4_en_off", cnt_en, 1'b0);
            if (c == 18) check("t4_done", done, 4'b0100);
        end
        check("t4_nowrap", cnt, 4'd15);
        check("t4_busy", busy, 1'b0);

        // 5: reset asserted during COUNT at out=2
        req = 4'b0010;
        tgt = 16'h0070;
        repeat (4) tick();
        check("t5_pre_out", cnt, 4'd2);
        rst = 1'b0;
        #1;
        check("t5_gnt",  gnt,  4'b0000);
        check("t5_busy", busy, 1'b0);
        check("t5_en",   cnt_en, 1'b0);
        check("t5_done", done, 4'b0000);
        tick();
        check("t5_hold_done", done, 4'b0000);
        rst = 1'b1;
        tick();
        check("t5_restart_gnt", gnt, 4'b0010);
        check("t5_restart_clr", cnt_clr, 1'b1);
        req = 4'b0000;
        wait_idle("t5", 4'b0010, 1);

        // 6: frozen counter
        do_reset();
        freeze = 1'b1;
        req = 4'b0001;
        tgt = 16'h0005;
        err_seen = 0;
`ifdef CNT_CTRL_WDOG_EN
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            if (err) err_seen++;
            if (c == 19) check("t6_err", err, 1'b1);
            if (c == 19) check("t6_done", done, 4'b0001);
        end
        check("t6_err_once", err_seen, 1);
        check("t6_idle", busy, 1'b0);
`else
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 1) req = 4'b0000;
            if (err) err_seen++;
        end
        check("t6_no_err", err_seen, 0);
        check("t6_waiting", busy, 1'b1);
        check("t6_gnt", gnt, 4'b0001);
`endif
        freeze = 1'b0;
        do_reset();
        check("t6_post_rst", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
